sprite_row_blitter: RTL and testbench

- Parametrised successor to the mole/scoreboard drawer: renders a row of NUM_SLOTS sprites, each SPR_W x SPR_H, into the vga_adapter plot interface.
- Runs once per frame_tick, entirely in the CLOCK_50 domain; no second clock.
- Each slot selects one of 2^FRAME_W animation frames from an external sprite ROM.
- Adds per-slot enable, optional transparent-colour skip, a configurable ROM read latency, a busy/done handshake and an overrun flag.

---
 rtl/sprite_row_blitter_pkg.sv | 22 ++
 rtl/sprite_row_blitter_pipe.sv | 45 ++++
 rtl/sprite_row_blitter.sv | 165 ++++++++++++++++
 tb/tb_sprite_row_blitter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_row_blitter_pkg.sv
// Shared types, widths and helpers for the sprite row blitter.
package sprite_row_blitter_pkg;

    localparam int VGA_XW = 8;
    localparam int VGA_YW = 7;
    localparam int COL_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } blit_state_t;

    // ceil(log2(n)), never below 1 so the result can size a counter
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sprite_row_blitter_pipe.sv
// Valid/x/y delay line that keeps pixel coordinates aligned
// with the ROM read latency.
module blit_pipe #(
    parameter int DEPTH = 1,
    parameter int XW    = 8,
    parameter int YW    = 7
) (
    input  logic          Clock,
    input  logic          resetn,
    input  logic          in_valid,
    input  logic [XW-1:0] in_x,
    input  logic [YW-1:0] in_y,
    output logic          out_valid,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y
);

    logic [DEPTH-1:0] v;
    logic [XW-1:0]    xs [DEPTH];
    logic [YW-1:0]    ys [DEPTH];

    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
        end else begin
            v[0]  <= in_valid;
            xs[0] <= in_x;
            ys[0] <= in_y;
            for (int i = 1; i < DEPTH; i++) begin
                v[i]  <= v[i-1];
                xs[i] <= xs[i-1];
                ys[i] <= ys[i-1];
            end
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_x     = xs[DEPTH-1];
    assign out_y     = ys[DEPTH-1];

endmodule

// File: rtl/sprite_row_blitter.sv
// Draws a row of animated sprites from an external ROM into the
// vga_adapter plot port, one pixel address per cycle.
module sprite_row_blitter
    import sprite_row_blitter_pkg::*;
#(
    parameter int               NUM_SLOTS  = 8,
    parameter int               SPR_W      = 16,
    parameter int               SPR_H      = 20,
    parameter int               FRAME_W    = 2,
    parameter int               ROM_AW     = 11,
    parameter int               X0         = 2,
    parameter int               Y0         = 100,
    parameter int               PITCH      = 18,
    parameter int               ROM_LAT    = 1,
    parameter bit               TRANSP_EN  = 1'b0,
    parameter logic [COL_W-1:0] TRANSP_COL = 3'b000
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    input  logic                         frame_tick,
    input  logic [NUM_SLOTS-1:0]         slot_enable,
    input  logic [NUM_SLOTS*FRAME_W-1:0] slot_frames,
    output logic [ROM_AW-1:0]            rom_addr,
    input  logic [COL_W-1:0]             rom_q,
    output logic [VGA_XW-1:0]            x,
    output logic [VGA_YW-1:0]            y,
    output logic [COL_W-1:0]             colour,
    output logic                         plot,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);

    localparam int SLOT_W = clog2(NUM_SLOTS);
    localparam int CCW    = clog2(SPR_W);
    localparam int RCW    = clog2(SPR_H);
    localparam int DRW    = clog2(ROM_LAT + 1);

    blit_state_t                  state;
    logic [SLOT_W-1:0]            slot;
    logic [CCW-1:0]               col;
    logic [RCW-1:0]               row;
    logic [DRW-1:0]               drn;
    logic [NUM_SLOTS-1:0]         en_q;
    logic [NUM_SLOTS*FRAME_W-1:0] fr_q;

    logic [FRAME_W-1:0] fr_cur;
    logic               issue;
    logic               col_end;
    logic               row_end;
    logic               slot_end;
    logic [VGA_XW-1:0]  x_iss;
    logic [VGA_YW-1:0]  y_iss;
    logic               pv;
    logic [VGA_XW-1:0]  px;
    logic [VGA_YW-1:0]  py;

    assign fr_cur   = fr_q[int'(slot)*FRAME_W +: FRAME_W];
    assign issue    = (state == SCAN) && en_q[slot];
    assign col_end  = col == CCW'(SPR_W - 1);
    assign row_end  = row == RCW'(SPR_H - 1);
    assign slot_end = slot == SLOT_W'(NUM_SLOTS - 1);

    assign rom_addr = issue
        ? ROM_AW'(int'(fr_cur) * SPR_W * SPR_H
                  + int'(row) * SPR_W + int'(col))
        : '0;

    assign x_iss = VGA_XW'(X0 + int'(slot) * PITCH + int'(col));
    assign y_iss = VGA_YW'(Y0 + int'(row));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            slot    <= '0;
            col     <= '0;
            row     <= '0;
            drn     <= '0;
            en_q    <= '0;
            fr_q    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done <= 1'b0;
            // a tick in the done cycle counts as arriving while busy
            if (frame_tick && (state != IDLE || done))
                overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (frame_tick && !done) begin
                        en_q  <= slot_enable;
                        fr_q  <= slot_frames;
                        slot  <= '0;
                        col   <= '0;
                        row   <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!en_q[slot] || (col_end && row_end)) begin
                        col <= '0;
                        row <= '0;
                        if (slot_end) begin
                            slot  <= '0;
                            drn   <= '0;
                            state <= DRAIN;
                        end else begin
                            slot <= slot + 1'b1;
                        end
                    end else if (col_end) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                // covers the delay line plus the plot output register
                DRAIN: begin
                    if (drn == DRW'(ROM_LAT))
                        state <= DONE;
                    else
                        drn <= drn + 1'b1;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    blit_pipe #(
        .DEPTH (ROM_LAT),
        .XW    (VGA_XW),
        .YW    (VGA_YW)
    ) u_pipe (
        .Clock     (CLOCK_50),
        .resetn    (resetn),
        .in_valid  (issue),
        .in_x      (x_iss),
        .in_y      (y_iss),
        .out_valid (pv),
        .out_x     (px),
        .out_y     (py)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else begin
            plot   <= pv && !(TRANSP_EN && rom_q == TRANSP_COL);
            x      <= px;
            y      <= py;
            colour <= rom_q;
        end
    end

endmodule

// File: tb/tb_sprite_row_blitter.sv
// Directed-plus-random bench for sprite_row_blitter against a
// frame-level pixel list model, with default and ROM_LAT=3/transparent DUTs.
module tb_sprite_row_blitter;

    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  c;
        logic [31:0] t;
    } pix_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_tick = 1'b0;
    logic [7:0]  slot_enable = '0;
    logic [15:0] slot_frames = '0;

    logic [10:0] addr0, addr1;
    logic [2:0]  q0 = '0, q1a = '0, q1b = '0, q1c = '0;
    logic [7:0]  x0, x1;
    logic [6:0]  y0, y1;
    logic [2:0]  c0, c1;
    logic        plot0, plot1, busy0, busy1, done0, done1, ovr0, ovr1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: DUT0 a scrambled pattern, DUT1 zero on even addresses
    function automatic logic [2:0] rom_fn(input int d, input int a);
        if (d == 0) return 3'(a ^ (a >> 3) ^ (a >> 7));
        return a[0] ? 3'(1 + (a >> 1) % 7) : 3'd0;
    endfunction

    always @(posedge clk) begin
        q0  <= rom_fn(0, int'(addr0));
        q1a <= rom_fn(1, int'(addr1));
        q1b <= q1a;
        q1c <= q1b;
    end

    sprite_row_blitter dut0 (
        .CLOCK_50(clk), .resetn(resetn), .frame_tick(frame_tick),
        .slot_enable(slot_enable), .slot_frames(slot_frames),
        .rom_addr(addr0), .rom_q(q0), .x(x0), .y(y0), .colour(c0),
        .plot(plot0), .busy(busy0), .done(done0), .overrun(ovr0)
    );

    sprite_row_blitter #(.ROM_LAT(3), .TRANSP_EN(1'b1)) dut1 (
        .CLOCK_50(clk), .resetn(resetn), .frame_tick(frame_tick),
        .slot_enable(slot_enable), .slot_frames(slot_frames),
        .rom_addr(addr1), .rom_q(q1c), .x(x1), .y(y1), .colour(c1),
        .plot(plot1), .busy(busy1), .done(done1), .overrun(ovr1)
    );

    pix_t obs0[$];
    pix_t obs1[$];
    int   dn0 = 0, dn1 = 0, dc0 = 0, dc1 = 0;
    logic db0 = 1'b0, db1 = 1'b0;

    always @(negedge clk) begin
        if (plot0) obs0.push_back(pix_t'{x: x0, y: y0, c: c0, t: cyc});
        if (plot1) obs1.push_back(pix_t'{x: x1, y: y1, c: c1, t: cyc});
        if (done0) begin dn0 <= dn0 + 1; dc0 <= cyc; db0 <= busy0; end
        if (done1) begin dn1 <= dn1 + 1; dc1 <= cyc; db1 <= busy1; end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int t0, b0, b1, d0, d1;

    task automatic start_draw(input logic [7:0] en, input logic [15:0] fr);
        repeat (2) @(negedge clk);
        slot_enable = en;
        slot_frames = fr;
        b0 = obs0.size();
        b1 = obs1.size();
        d0 = dn0;
        d1 = dn1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        t0 = cyc;
        chk("busy0 after tick", busy0, 1);
        chk("busy1 after tick", busy1, 1);
    endtask

    task automatic wait_draw(input string tag);
        int n = 0;
        while ((dn0 == d0 || dn1 == d1) && n < 6000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, " finished in budget"}, (dn0 != d0 && dn1 != d1), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_draw(input int d, input logic [7:0] en,
                              input logic [15:0] fr, input string tag);
        pix_t e[$];
        pix_t g;
        int   lat = (d == 0) ? 1 : 3;
        int   t = 0;
        int   n;
        for (int s = 0; s < 8; s++) begin
            if (!en[s]) begin
                t++;
                continue;
            end
            for (int r = 0; r < 20; r++) begin
                for (int c = 0; c < 16; c++) begin
                    int a;
                    logic [2:0] k;
                    a = int'(fr[2*s +: 2]) * 320 + r * 16 + c;
                    k = rom_fn(d, a);
                    if (d == 0 || k != 3'd0)
                        e.push_back(pix_t'{x: 8'(2 + 18 * s + c),
                                           y: 7'(100 + r), c: k,
                                           t: t0 + t + lat + 1});
                    t++;
                end
            end
        end
        n = (d == 0) ? obs0.size() - b0 : obs1.size() - b1;
        chk({tag, " plot count"}, n, e.size());
        for (int i = 0; i < e.size() && i < n; i++) begin
            g = (d == 0) ? obs0[b0 + i] : obs1[b1 + i];
            chk($sformatf("%s px%0d", tag, i), g, e[i]);
        end
        chk({tag, " done cycle"}, ((d == 0) ? dc0 : dc1) - t0, t + lat + 2);
        chk({tag, " single done"}, (d == 0) ? dn0 - d0 : dn1 - d1, 1);
        chk({tag, " busy at done"}, (d == 0) ? db0 : db1, 0);
        chk({tag, " busy after"}, (d == 0) ? busy0 : busy1, 0);
    endtask

    initial begin
        pix_t        g;
        int          z;
        logic [7:0]  en;
        logic [15:0] fr;

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst plot0", plot0, 0);
        chk("rst busy0", busy0, 0);
        chk("rst done0", done0, 0);
        chk("rst ovr0", ovr0, 0);
        chk("rst xyc0", {x0, y0, c0}, 0);
        chk("rst addr0", addr0, 0);
        chk("rst plot1", plot1, 0);
        chk("rst busy1", busy1, 0);
        chk("rst ovr1", ovr1, 0);
        chk("rst addr1", addr1, 0);
        @(negedge clk);
        resetn = 1'b1;

        // all slots, frame 0
        start_draw(8'hFF, 16'h0000);
        wait_draw("A");
        check_draw(0, 8'hFF, 16'h0000, "A0");
        check_draw(1, 8'hFF, 16'h0000, "A1");
        chk("A0 total plots", obs0.size() - b0, 2560);
        chk("A1 total plots", obs1.size() - b1, 1280);
        chk("A0 done at", dc0 - t0, 2563);
        chk("A1 done at", dc1 - t0, 2565);
        if (obs0.size() > b0) begin
            g = obs0[b0];
            chk("A0 first x", g.x, 2);
            chk("A0 first y", g.y, 100);
            chk("A0 first t", g.t - t0, 2);
            g = obs0[obs0.size() - 1];
            chk("A0 last x", g.x, 143);
            chk("A0 last y", g.y, 119);
        end else begin
            chk("A0 any plot", 0, 1);
        end
        z = 0;
        for (int i = b1; i < obs1.size(); i++)
            if (obs1[i].c == 3'd0) z++;
        chk("A1 transparent plots", z, 0);

        // single slot 2, frame 2
        fr = 16'($urandom);
        fr[5:4] = 2'd2;
        start_draw(8'b0000_0100, fr);
        wait_draw("B");
        check_draw(0, 8'b0000_0100, fr, "B0");
        check_draw(1, 8'b0000_0100, fr, "B1");
        chk("B0 done at", dc0 - t0, 330);
        if (obs0.size() > b0) chk("B0 first x", obs0[b0].x, 38);

        // boundaries: nothing enabled, last slot only
        start_draw(8'h00, 16'hFFFF);
        wait_draw("E");
        check_draw(0, 8'h00, 16'hFFFF, "E0");
        check_draw(1, 8'h00, 16'hFFFF, "E1");
        fr = 16'($urandom);
        start_draw(8'h80, fr);
        wait_draw("L");
        check_draw(0, 8'h80, fr, "L0");
        check_draw(1, 8'h80, fr, "L1");

        // random enables and frames
        for (int k = 0; k < 3; k++) begin
            en = 8'($urandom);
            fr = 16'($urandom);
            start_draw(en, fr);
            wait_draw($sformatf("R%0d", k));
            check_draw(0, en, fr, $sformatf("R%0d.0", k));
            check_draw(1, en, fr, $sformatf("R%0d.1", k));
        end

        // late tick and frame change mid-draw
        fr = 16'($urandom);
        start_draw(8'hFF, fr);
        repeat (49) @(negedge clk);
        slot_frames = ~fr;
        repeat (50) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("O ovr0 set", ovr0, 1);
        chk("O ovr1 set", ovr1, 1);
        wait_draw("O");
        check_draw(0, 8'hFF, fr, "O0");
        check_draw(1, 8'hFF, fr, "O1");
        repeat (20) @(negedge clk);
        chk("O ovr0 held", ovr0, 1);
        chk("O ovr1 held", ovr1, 1);
        chk("O no restart0", busy0, 0);

        // async reset mid-scan
        fr = 16'($urandom);
        start_draw(8'hFF, fr);
        repeat (500) @(negedge clk);
        chk("M plot0 before rst", plot0, 1);
        resetn = 1'b0;
        #1;
        chk("M plot0 async", plot0, 0);
        chk("M busy0 async", busy0, 0);
        chk("M ovr0 async", ovr0, 0);
        chk("M plot1 async", plot1, 0);
        chk("M busy1 async", busy1, 0);
        chk("M ovr1 async", ovr1, 0);
        @(negedge clk);
        resetn = 1'b1;
        fr = 16'($urandom);
        start_draw(8'hFF, fr);
        wait_draw("P");
        check_draw(0, 8'hFF, fr, "P0");
        check_draw(1, 8'hFF, fr, "P1");
        chk("P ovr0 clear", ovr0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
